// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional zero register, same-cycle
// write-to-read bypass and a multi-cycle soft-clear sequencer.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] wa,
  input  logic [NUM_WR*DATA_W-1:0] wd,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] PTR_LAST = (ADDR_W+1)'(DEPTH - 1);

  // Clear handshake: clr_req is sampled only in IDLE; clr_busy is high for
  // exactly DEPTH cycles while registers are zeroed one per cycle, then
  // clr_done pulses for one cycle. Requests during CLEAR/DONE are dropped.
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_e;

  clr_state_e        state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0] regs [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == PTR_LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign clr_busy = (state_q == CLEAR);
  assign clr_done = (state_q == DONE);

  // Ascending port loop: with non-blocking writes the highest port wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
    end else if (state_q == CLEAR) begin
      regs[ptr_q[ADDR_W-1:0]] <= '0;
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (we[i] && !((ZERO_REG != 0) && (wa[i*ADDR_W +: ADDR_W] == '0)))
          regs[wa[i*ADDR_W +: ADDR_W]] <= wd[i*DATA_W +: DATA_W];
      end
    end
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [ADDR_W-1:0] ra_j;
    logic [DATA_W-1:0] rd_v;

    assign ra_j = ra[j*ADDR_W +: ADDR_W];

    always_comb begin
      rd_v = regs[ra_j];
      if (BYPASS != 0) begin
        for (int i = 0; i < NUM_WR; i++) begin
          if (we[i] && (wa[i*ADDR_W +: ADDR_W] == ra_j)) rd_v = wd[i*DATA_W +: DATA_W];
        end
      end
      if ((ZERO_REG != 0) && (ra_j == '0)) rd_v = '0;
      if (state_q == CLEAR) rd_v = '0;
    end

    assign rd[j*DATA_W +: DATA_W] = rd_v;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a bypassing and a non-bypassing instance
// share stimulus and are compared against an array-based reference model.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  we;
  logic [11:0] wa;
  logic [63:0] wd;
  logic [11:0] ra;
  logic        clr_req;
  logic [63:0] rd, rd_nb;
  logic        clr_busy, clr_done, clr_busy_nb, clr_done_nb;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // reference model state
  logic [31:0] mem [64];
  int          clr_left;
  bit          done_m;

  regfile_mp #(.DATA_W(32), .ADDR_W(6), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(6), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_nb),
    .clr_req(clr_req), .clr_busy(clr_busy_nb), .clr_done(clr_done_nb)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model
  function automatic logic [5:0] f_wa(input int i);
    logic [11:0] v = wa;
    return v[i*6 +: 6];
  endfunction

  function automatic logic [31:0] f_wd(input int i);
    logic [63:0] v = wd;
    return v[i*32 +: 32];
  endfunction

  function automatic logic [31:0] model_rd(input logic [5:0] a, input bit byp);
    logic [31:0] r;
    if (clr_left > 0) return 32'h0;
    if (a == 6'd0) return 32'h0;
    r = mem[a];
    if (byp)
      for (int i = 0; i < 2; i++)
        if (we[i] && f_wa(i) == a) r = f_wd(i);
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 64; k++) mem[k] = 32'h0;
    clr_left = 0;
    done_m = 1'b0;
  endtask

  task automatic model_edge();
    if (clr_left > 0) begin
      clr_left--;
      if (clr_left == 0) begin
        for (int k = 0; k < 64; k++) mem[k] = 32'h0;
        done_m = 1'b1;
      end
    end else begin
      for (int i = 0; i < 2; i++)
        if (we[i] && f_wa(i) != 6'd0) mem[f_wa(i)] = f_wd(i);
      if (done_m) done_m = 1'b0;
      else if (clr_req) clr_left = 64;
    end
  endtask

  // driver: inputs are set at the falling edge; outputs checked 1ns later
  task automatic set_in(input logic [1:0] w, input logic [5:0] a0, input logic [31:0] d0,
                        input logic [5:0] a1, input logic [31:0] d1,
                        input logic [5:0] r0, input logic [5:0] r1, input logic c);
    we = w; wa = {a1, a0}; wd = {d1, d0}; ra = {r1, r0}; clr_req = c;
  endtask

  task automatic compare_now();
    logic [11:0] rv = ra;
    exp_q.push_back(model_rd(rv[5:0], 1'b1));
    exp_q.push_back(model_rd(rv[11:6], 1'b1));
    exp_q.push_back(model_rd(rv[5:0], 1'b0));
    exp_q.push_back(model_rd(rv[11:6], 1'b0));
    exp_q.push_back({31'd0, clr_left > 0});
    exp_q.push_back({31'd0, done_m});
    check("rd0", rd[31:0], exp_q.pop_front());
    check("rd1", rd[63:32], exp_q.pop_front());
    check("rd0_nobyp", rd_nb[31:0], exp_q.pop_front());
    check("rd1_nobyp", rd_nb[63:32], exp_q.pop_front());
    check("clr_busy", {31'd0, clr_busy}, exp_q.pop_front());
    check("clr_done", {31'd0, clr_done}, exp_q.pop_front());
  endtask

  task automatic step();
    #1;
    compare_now();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic read_all();
    for (int k = 0; k < 32; k++) begin
      set_in(2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 6'(k), 6'(k + 32), 1'b0);
      step();
    end
  endtask

  task automatic rand_cycles(input int n, input int clr_odds);
    logic [5:0] a0, a1, r0, r1;
    for (int k = 0; k < n; k++) begin
      a0 = 6'($urandom_range(0, 63));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : 6'($urandom_range(0, 63));
      r0 = ($urandom_range(0, 1) == 0) ? a0 : 6'($urandom_range(0, 63));
      r1 = ($urandom_range(0, 1) == 0) ? a1 : 6'($urandom_range(0, 63));
      set_in(2'($urandom_range(0, 3)), a0, $urandom, a1, $urandom, r0, r1,
             (clr_odds > 0) && ($urandom_range(1, clr_odds) == 1));
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    set_in(2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 6'd0, 6'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    compare_now();
    rst_n = 1'b1;

    // reset state on every address
    read_all();

    // random traffic to populate
    rand_cycles(200, 0);

    // async reset pulse between edges, no clock edge involved
    set_in(2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 6'd1, 6'd2, 1'b0);
    #1 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    model_reset();
    check("rd0_after_pulse", rd[31:0], 32'h0);
    @(negedge clk);
    read_all();

    // bypass on address 5
    set_in(2'b01, 6'd5, 32'hDEAD_BEEF, 6'd0, 32'h0, 6'd5, 6'd5, 1'b0);
    step();
    set_in(2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 6'd5, 6'd5, 1'b0);
    step();
    // write-write conflict on address 9
    set_in(2'b11, 6'd9, 32'd1, 6'd9, 32'd2, 6'd9, 6'd9, 1'b0);
    step();
    set_in(2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 6'd9, 6'd0, 1'b0);
    step();
    // zero register
    set_in(2'b11, 6'd0, 32'h1234, 6'd0, 32'h1234, 6'd0, 6'd0, 1'b0);
    step();
    set_in(2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 6'd0, 6'd0, 1'b0);
    step();

    // fill 1..63 with index
    for (int k = 1; k < 64; k += 2) begin
      set_in((k + 1 < 64) ? 2'b11 : 2'b01, 6'(k), 32'(k), 6'(k + 1), 32'(k + 1),
             6'(k), 6'(k + 1), 1'b0);
      step();
    end
    read_all();

    // soft clear: write to 7 and a second request during busy are ignored
    set_in(2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 6'd7, 6'd8, 1'b1);
    step();
    for (int k = 0; k < 66; k++) begin
      set_in((k == 10) ? 2'b01 : 2'b00, 6'd7, 32'h7777, 6'd0, 32'h0,
             6'(k), 6'd7, (k == 30) ? 1'b1 : 1'b0);
      step();
    end
    read_all();

    // reset mid-clear at pointer 20
    for (int k = 1; k < 64; k++) begin
      set_in(2'b01, 6'(k), 32'(k), 6'd0, 32'h0, 6'd1, 6'd2, 1'b0);
      step();
    end
    set_in(2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 6'd1, 6'd2, 1'b1);
    step();
    set_in(2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 6'd1, 6'd2, 1'b0);
    for (int k = 0; k < 20; k++) step();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("busy_abort", {31'd0, clr_busy}, 32'h0);
    check("done_abort", {31'd0, clr_done}, 32'h0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    read_all();
    set_in(2'b01, 6'd3, 32'd3, 6'd0, 32'h0, 6'd3, 6'd4, 1'b0);
    step();
    set_in(2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 6'd3, 6'd3, 1'b0);
    step();

    // random traffic with occasional clears
    rand_cycles(400, 40);
    read_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file; successor to the single-write/dual-read CPU register file.
- Configurable data width, depth, read-port count and write-port count.
- Optional hardwired zero register and same-cycle write-to-read bypass.
- Multi-cycle soft-clear sequencer lets the pipeline flush architectural state without asserting reset.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of read ports (>=1)
- NUM_WR, 2, number of write ports (>=1)
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes
- BYPASS, 1, 1 = a read returns write data being written in the same cycle

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- we  in  NUM_WR  per-port write enable
- wa  in  NUM_WR*ADDR_W  write addresses; port i at bits [i*ADDR_W +: ADDR_W]
- wd  in  NUM_WR*DATA_W  write data; port i at bits [i*DATA_W +: DATA_W]
- ra  in  NUM_RD*ADDR_W  read addresses, packed the same way
- rd  out  NUM_RD*DATA_W  read data, combinational from ra, packed the same way
- clr_req  in  1  request soft clear of all registers
- clr_busy  out  1  soft clear in progress
- clr_done  out  1  one-cycle pulse when soft clear completes

Behaviour:
- Reset (rst_n low, async): all registers 0; FSM = IDLE; clr_busy = 0; clr_done = 0; clear pointer = 0.
  - rd is then 0 for every address.
  - Reset asserted mid-clear aborts the clear immediately; no clr_done pulse.
- Write timing: regs[wa[i]] <= wd[i] at the rising edge where we[i] = 1, FSM != CLEAR and rst_n = 1.
- Write-write conflict (same address, multiple enabled ports): the highest-indexed port wins.
- ZERO_REG = 1: writes to address 0 are dropped; reads of address 0 return 0 (bypass included).
- Reads are combinational: rd[j] = regs[ra[j]], zero read latency.
- BYPASS = 1 and FSM != CLEAR: if any enabled write port targets ra[j] this cycle, rd[j] = wd of the highest such port. Otherwise rd[j] = stored value.
- BYPASS = 0: rd shows the old value until after the edge.
- Soft-clear FSM, states IDLE, CLEAR, DONE:
  - IDLE: clr_req = 1 at an edge -> CLEAR, pointer = 0.
  - CLEAR: each edge zeroes regs[pointer] and increments the pointer. At the edge with pointer = DEPTH-1 -> DONE. CLEAR lasts exactly DEPTH cycles.
  - DONE: lasts one cycle, then -> IDLE. clr_req sampled in DONE is ignored.
- Clear outputs and side effects:
  - clr_busy = 1 exactly while FSM = CLEAR.
  - clr_done = 1 exactly while FSM = DONE.
  - During CLEAR: all writes are dropped (no partial state); every rd returns 0 regardless of address or bypass.
  - During CLEAR: clr_req is ignored (no restart, no queuing).
  - In DONE: writes are accepted and bypass works normally.
- Latency: clr_req high at edge N -> clr_busy high for cycles N+1..N+DEPTH -> clr_done high in cycle N+DEPTH+1.
- Pointer is ADDR_W+1 bits or compares against DEPTH-1; it must not wrap early for any ADDR_W.
- Out-of-range port packing is impossible by construction; all address values are legal.

Test Plan:
- Reset, then read all 64 addresses on both read ports -> every rd = 0. Pulse rst_n low for 3 ns between edges -> array returns to 0 without a clock edge.
- we = 2'b01, wa0 = 5, wd0 = 32'hDEAD_BEEF, ra0 = 5, BYPASS = 1 -> rd0 = DEAD_BEEF in the same cycle. With BYPASS = 0 -> rd0 = 0 that cycle, DEAD_BEEF next cycle.
- we = 2'b11, wa0 = wa1 = 9, wd0 = 1, wd1 = 2 -> after the edge regs[9] reads 2. Same-cycle bypass on ra = 9 also returns 2.
- ZERO_REG = 1: write 32'h1234 to address 0 on both ports -> rd for address 0 is 0 in the same cycle and after the edge.
- Fill registers 1..63 with value = index; pulse clr_req at edge N -> clr_busy high for N+1..N+64 with all rd = 0. Write to address 7 during busy is dropped. clr_done pulses at N+65. Afterwards all registers read 0. A second clr_req during busy has no effect.
- Start a clear, assert rst_n low at pointer = 20 -> clr_busy drops asynchronously, no clr_done, all registers 0. After release, a write to 3 (value 3) reads back 3.
